// File: rtl/otter_cu_fsm_decoder.sv
// OTTER control unit: multicycle FSM merged with the instruction decoder.
// Optional ENC_WAIT timeout watchdog compiled in with `define CU_ENC_TIMEOUT_EN.
module otter_cu_fsm_decoder #(
    parameter int unsigned IRQ_W       = 4,
    parameter int unsigned PCSRC_W     = 4,
    parameter int unsigned ENC_TIMEOUT = 64
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [6:0]         CU_OPCODE,
    input  logic [2:0]         CU_FUNC3,
    input  logic [6:0]         CU_FUNC7,
    input  logic               CU_BR_EQ,
    input  logic               CU_BR_LT,
    input  logic               CU_BR_LTU,
    input  logic [IRQ_W-1:0]   CU_IRQ,
    input  logic [IRQ_W-1:0]   CU_IRQ_MASK,
    input  logic               CU_MIE,
    input  logic               CU_ENC_DONE,
    output logic               CU_PC_WRITE,
    output logic               CU_REG_WRITE,
    output logic               CU_MEM_WE,
    output logic               CU_MEM_RDEN1,
    output logic               CU_MEM_RDEN2,
    output logic               CU_CSR_WE,
    output logic               CU_ENC_START,
    output logic               CU_INT_TAKEN,
    output logic [((IRQ_W > 1) ? $clog2(IRQ_W) : 1)-1:0] CU_INT_CAUSE,
    output logic               CU_ILLEGAL,
    output logic               CU_ENC_ERR,
    output logic               CU_ALU_SRCA,
    output logic [1:0]         CU_ALU_SRCB,
    output logic [3:0]         CU_ALU_FUN,
    output logic [1:0]         CU_RF_WR_SEL,
    output logic [PCSRC_W-1:0] CU_PCSOURCE
);

    localparam int unsigned CAUSE_W = (IRQ_W > 1) ? $clog2(IRQ_W) : 1;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_ENCRY  = 7'b0011100;

    typedef enum logic [2:0] {
        ST_FETCH    = 3'd0,
        ST_EXEC     = 3'd1,
        ST_WB       = 3'd2,
        ST_ENC_WAIT = 3'd3,
        ST_INTR     = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic               br_taken_c;
    logic [2:0]         pcsrc_c;
    logic [IRQ_W-1:0]   irq_act_c;
    logic               pending_c;
    logic [CAUSE_W-1:0] cause_c;

    logic pc_write_c, reg_write_c, mem_we_c, rden1_c, rden2_c, csr_we_c;
    logic enc_start_c, int_taken_c, illegal_c, enc_err_c;
    logic enc_wait_exit_c;

    // Only f7[5] carries meaning for this ISA subset.
    logic unused_func7;
    assign unused_func7 = ^{CU_FUNC7[6], CU_FUNC7[4:0]};

    // Branch condition from func3 and the comparator flags
    always_comb begin
        br_taken_c = 1'b0;
        case (CU_FUNC3)
            3'b000:  br_taken_c = CU_BR_EQ;
            3'b001:  br_taken_c = ~CU_BR_EQ;
            3'b100:  br_taken_c = CU_BR_LT;
            3'b101:  br_taken_c = ~CU_BR_LT;
            3'b110:  br_taken_c = CU_BR_LTU;
            3'b111:  br_taken_c = ~CU_BR_LTU;
            default: br_taken_c = 1'b0;
        endcase
    end

    // Datapath mux/ALU decode, combinational in every state
    always_comb begin
        CU_ALU_FUN   = 4'b0000;
        CU_ALU_SRCA  = 1'b0;
        CU_ALU_SRCB  = 2'd0;
        CU_RF_WR_SEL = 2'd3;
        pcsrc_c      = 3'd0;
        case (CU_OPCODE)
            OPC_OP:     CU_ALU_FUN = {CU_FUNC7[5], CU_FUNC3};
            OPC_OP_IMM: begin
                CU_ALU_FUN  = (CU_FUNC3 == 3'b101) ? {CU_FUNC7[5], CU_FUNC3} : {1'b0, CU_FUNC3};
                CU_ALU_SRCB = 2'd1;
            end
            OPC_LUI: begin
                CU_ALU_FUN  = 4'b1001;
                CU_ALU_SRCA = 1'b1;
            end
            OPC_AUIPC: begin
                CU_ALU_SRCA = 1'b1;
                CU_ALU_SRCB = 2'd3;
            end
            OPC_SYSTEM: begin
                CU_ALU_FUN   = 4'b1001;
                CU_RF_WR_SEL = 2'd1;
                if (CU_FUNC3 == 3'b000) pcsrc_c = 3'd5;
            end
            OPC_JAL: begin
                CU_RF_WR_SEL = 2'd0;
                pcsrc_c      = 3'd3;
            end
            OPC_JALR: begin
                CU_ALU_SRCB  = 2'd1;
                CU_RF_WR_SEL = 2'd0;
                pcsrc_c      = 3'd1;
            end
            OPC_LOAD: begin
                CU_ALU_SRCB  = 2'd1;
                CU_RF_WR_SEL = 2'd2;
            end
            OPC_STORE:  CU_ALU_SRCB = 2'd2;
            OPC_BRANCH: pcsrc_c = br_taken_c ? 3'd2 : 3'd0;
            default: ;
        endcase
    end

    // Interrupt trap redirects the PC regardless of the current instruction
    assign CU_PCSOURCE = (state == ST_INTR) ? PCSRC_W'(3'd4) : PCSRC_W'(pcsrc_c);

    // Pending request and lowest-index priority encoding of active lines
    assign irq_act_c = CU_IRQ & CU_IRQ_MASK;
    assign pending_c = CU_MIE & (|irq_act_c);

    always_comb begin
        cause_c = '0;
        for (int i = int'(IRQ_W) - 1; i >= 0; i--) begin
            if (irq_act_c[i]) cause_c = CAUSE_W'(i);
        end
    end

`ifdef CU_ENC_TIMEOUT_EN
    localparam int unsigned TO_W = (ENC_TIMEOUT > 2) ? $clog2(ENC_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ENC_TIMEOUT - 1);

    logic [TO_W-1:0] enc_cnt;
    logic            enc_expired_c;

    assign enc_expired_c = (enc_cnt == TO_LAST);

    // ENC_WAIT cycle counter, cleared on entry
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            enc_cnt <= '0;
        end else if (state == ST_EXEC && state_nxt == ST_ENC_WAIT) begin
            enc_cnt <= '0;
        end else if (state == ST_ENC_WAIT) begin
            enc_cnt <= enc_cnt + TO_W'(1);
        end
    end
`else
    logic unused_enc_cfg;
    assign unused_enc_cfg = ^32'(ENC_TIMEOUT);
`endif

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= ST_FETCH;
        else        state <= state_nxt;
    end

    // Interrupt cause latched on trap entry
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)                CU_INT_CAUSE <= '0;
        else if (state == ST_INTR) CU_INT_CAUSE <= cause_c;
    end

    // Next-state and strobe generation
    always_comb begin
        state_nxt       = state;
        pc_write_c      = 1'b0;
        reg_write_c     = 1'b0;
        mem_we_c        = 1'b0;
        rden1_c         = 1'b0;
        rden2_c         = 1'b0;
        csr_we_c        = 1'b0;
        enc_start_c     = 1'b0;
        int_taken_c     = 1'b0;
        illegal_c       = 1'b0;
        enc_err_c       = 1'b0;
        enc_wait_exit_c = 1'b0;
        case (state)
            ST_FETCH: begin
                rden1_c   = 1'b1;
                state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                pc_write_c = 1'b1;
                state_nxt  = pending_c ? ST_INTR : ST_FETCH;
                case (CU_OPCODE)
                    OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP, OPC_OP_IMM:
                        reg_write_c = 1'b1;
                    OPC_SYSTEM: begin
                        reg_write_c = (CU_FUNC3 != 3'b000);
                        csr_we_c    = (CU_FUNC3 != 3'b000);
                    end
                    OPC_STORE:  mem_we_c = 1'b1;
                    OPC_BRANCH: ;
                    OPC_LOAD: begin
                        pc_write_c = 1'b0;
                        rden2_c    = 1'b1;
                        state_nxt  = ST_WB;
                    end
                    OPC_ENCRY: begin
                        pc_write_c  = 1'b0;
                        enc_start_c = 1'b1;
                        state_nxt   = ST_ENC_WAIT;
                    end
                    default: illegal_c = 1'b1;
                endcase
            end
            ST_WB: begin
                reg_write_c = 1'b1;
                pc_write_c  = 1'b1;
                state_nxt   = pending_c ? ST_INTR : ST_FETCH;
            end
            ST_ENC_WAIT: begin
                if (CU_ENC_DONE) begin
                    enc_wait_exit_c = 1'b1;
                end
`ifdef CU_ENC_TIMEOUT_EN
                else if (enc_expired_c) begin
                    enc_wait_exit_c = 1'b1;
                    enc_err_c       = 1'b1;
                end
`endif
                if (enc_wait_exit_c) begin
                    pc_write_c = 1'b1;
                    state_nxt  = pending_c ? ST_INTR : ST_FETCH;
                end
            end
            ST_INTR: begin
                int_taken_c = 1'b1;
                pc_write_c  = 1'b1;
                state_nxt   = ST_FETCH;
            end
            default: state_nxt = ST_FETCH;
        endcase
    end

    // Strobes are held low for the whole time reset is asserted
    assign CU_PC_WRITE  = pc_write_c  & RST_N;
    assign CU_REG_WRITE = reg_write_c & RST_N;
    assign CU_MEM_WE    = mem_we_c    & RST_N;
    assign CU_MEM_RDEN1 = rden1_c     & RST_N;
    assign CU_MEM_RDEN2 = rden2_c     & RST_N;
    assign CU_CSR_WE    = csr_we_c    & RST_N;
    assign CU_ENC_START = enc_start_c & RST_N;
    assign CU_INT_TAKEN = int_taken_c & RST_N;
    assign CU_ILLEGAL   = illegal_c   & RST_N;
    assign CU_ENC_ERR   = enc_err_c   & RST_N;

endmodule

// File: tb/tb_otter_cu_fsm_decoder.sv
// Directed bench for otter_cu_fsm_decoder: decode table plus multicycle sequences.
module tb_otter_cu_fsm_decoder;

    localparam logic [6:0] OP    = 7'b0110011;
    localparam logic [6:0] OPI   = 7'b0010011;
    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111;
    localparam logic [6:0] JAL   = 7'b1101111;
    localparam logic [6:0] JALR  = 7'b1100111;
    localparam logic [6:0] BR    = 7'b1100011;
    localparam logic [6:0] LD    = 7'b0000011;
    localparam logic [6:0] ST    = 7'b0100011;
    localparam logic [6:0] SYS   = 7'b1110011;
    localparam logic [6:0] ENC   = 7'b0011100;

    // strobe bit order: pcw regw memwe rden1 rden2 csrwe encstart inttaken illegal encerr
    localparam logic [9:0] S_NONE = 10'b00_0000_0000;
    localparam logic [9:0] S_PCW  = 10'b10_0000_0000;
    localparam logic [9:0] S_REGW = 10'b01_0000_0000;
    localparam logic [9:0] S_MEMW = 10'b00_1000_0000;
    localparam logic [9:0] S_RD1  = 10'b00_0100_0000;
    localparam logic [9:0] S_RD2  = 10'b00_0010_0000;
    localparam logic [9:0] S_CSR  = 10'b00_0001_0000;
    localparam logic [9:0] S_ENC  = 10'b00_0000_1000;
    localparam logic [9:0] S_INT  = 10'b00_0000_0100;
    localparam logic [9:0] S_ILL  = 10'b00_0000_0010;
    localparam logic [9:0] S_ERR  = 10'b00_0000_0001;

    typedef struct packed {
        logic [3:0] alu;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] rf;
        logic [3:0] pcs;
        logic [9:0] stb;
    } outs_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       eq;
        logic       lt;
        logic       ltu;
        logic [3:0] alu;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] rf;
        logic [3:0] pcs;
        logic [9:0] stb;
    } vec_t;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [6:0] CU_OPCODE;
    logic [2:0] CU_FUNC3;
    logic [6:0] CU_FUNC7;
    logic       CU_BR_EQ, CU_BR_LT, CU_BR_LTU;
    logic [3:0] CU_IRQ, CU_IRQ_MASK;
    logic       CU_MIE, CU_ENC_DONE;
    logic       CU_PC_WRITE, CU_REG_WRITE, CU_MEM_WE, CU_MEM_RDEN1, CU_MEM_RDEN2, CU_CSR_WE;
    logic       CU_ENC_START, CU_INT_TAKEN, CU_ILLEGAL, CU_ENC_ERR, CU_ALU_SRCA;
    logic [1:0] CU_INT_CAUSE;
    logic [1:0] CU_ALU_SRCB;
    logic [3:0] CU_ALU_FUN;
    logic [1:0] CU_RF_WR_SEL;
    logic [3:0] CU_PCSOURCE;

    int checks   = 0;
    int failures = 0;

    outs_t act;
    vec_t  vecs[20];

    otter_cu_fsm_decoder #(.IRQ_W(4), .PCSRC_W(4), .ENC_TIMEOUT(8)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .CU_OPCODE(CU_OPCODE), .CU_FUNC3(CU_FUNC3), .CU_FUNC7(CU_FUNC7),
        .CU_BR_EQ(CU_BR_EQ), .CU_BR_LT(CU_BR_LT), .CU_BR_LTU(CU_BR_LTU),
        .CU_IRQ(CU_IRQ), .CU_IRQ_MASK(CU_IRQ_MASK), .CU_MIE(CU_MIE),
        .CU_ENC_DONE(CU_ENC_DONE),
        .CU_PC_WRITE(CU_PC_WRITE), .CU_REG_WRITE(CU_REG_WRITE), .CU_MEM_WE(CU_MEM_WE),
        .CU_MEM_RDEN1(CU_MEM_RDEN1), .CU_MEM_RDEN2(CU_MEM_RDEN2), .CU_CSR_WE(CU_CSR_WE),
        .CU_ENC_START(CU_ENC_START), .CU_INT_TAKEN(CU_INT_TAKEN),
        .CU_INT_CAUSE(CU_INT_CAUSE), .CU_ILLEGAL(CU_ILLEGAL), .CU_ENC_ERR(CU_ENC_ERR),
        .CU_ALU_SRCA(CU_ALU_SRCA), .CU_ALU_SRCB(CU_ALU_SRCB), .CU_ALU_FUN(CU_ALU_FUN),
        .CU_RF_WR_SEL(CU_RF_WR_SEL), .CU_PCSOURCE(CU_PCSOURCE)
    );

    always #5 CLK = ~CLK;

    assign act = {CU_ALU_FUN, CU_ALU_SRCA, CU_ALU_SRCB, CU_RF_WR_SEL, CU_PCSOURCE,
                  CU_PC_WRITE, CU_REG_WRITE, CU_MEM_WE, CU_MEM_RDEN1, CU_MEM_RDEN2,
                  CU_CSR_WE, CU_ENC_START, CU_INT_TAKEN, CU_ILLEGAL, CU_ENC_ERR};

    function automatic outs_t mk(logic [3:0] alu, logic a, logic [1:0] b, logic [1:0] rf,
                                 logic [3:0] pcs, logic [9:0] stb);
        outs_t o;
        o.alu = alu; o.srca = a; o.srcb = b; o.rf = rf; o.pcs = pcs; o.stb = stb;
        return o;
    endfunction

    task automatic check(input string name, input outs_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic check_cause(input string name, input logic [1:0] exp);
        checks++;
        if (CU_INT_CAUSE !== exp) begin
            failures++;
            $display("FAIL %s cause got=%0d want=%0d", name, CU_INT_CAUSE, exp);
        end
    endtask

    // check the current state's outputs, then advance one clock
    task automatic cyc(input string name, input outs_t exp);
        #2;
        check(name, exp);
        @(posedge CLK);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        CU_OPCODE = op; CU_FUNC3 = f3; CU_FUNC7 = f7;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{OP,    3'b000, 7'h00, 0,0,0, 4'b0000, 0, 2'd0, 2'd3, 4'd0, S_PCW|S_REGW};
        vecs[1]  = '{OP,    3'b000, 7'h20, 0,0,0, 4'b1000, 0, 2'd0, 2'd3, 4'd0, S_PCW|S_REGW};
        vecs[2]  = '{OP,    3'b111, 7'h00, 0,0,0, 4'b0111, 0, 2'd0, 2'd3, 4'd0, S_PCW|S_REGW};
        vecs[3]  = '{OPI,   3'b101, 7'h20, 0,0,0, 4'b1101, 0, 2'd1, 2'd3, 4'd0, S_PCW|S_REGW};
        vecs[4]  = '{OPI,   3'b000, 7'h20, 0,0,0, 4'b0000, 0, 2'd1, 2'd3, 4'd0, S_PCW|S_REGW};
        vecs[5]  = '{LUI,   3'b000, 7'h00, 0,0,0, 4'b1001, 1, 2'd0, 2'd3, 4'd0, S_PCW|S_REGW};
        vecs[6]  = '{AUIPC, 3'b000, 7'h00, 0,0,0, 4'b0000, 1, 2'd3, 2'd3, 4'd0, S_PCW|S_REGW};
        vecs[7]  = '{JAL,   3'b000, 7'h00, 0,0,0, 4'b0000, 0, 2'd0, 2'd0, 4'd3, S_PCW|S_REGW};
        vecs[8]  = '{JALR,  3'b000, 7'h00, 0,0,0, 4'b0000, 0, 2'd1, 2'd0, 4'd1, S_PCW|S_REGW};
        vecs[9]  = '{BR,    3'b100, 7'h00, 0,1,0, 4'b0000, 0, 2'd0, 2'd3, 4'd2, S_PCW};
        vecs[10] = '{BR,    3'b100, 7'h00, 0,0,0, 4'b0000, 0, 2'd0, 2'd3, 4'd0, S_PCW};
        vecs[11] = '{BR,    3'b010, 7'h00, 1,1,1, 4'b0000, 0, 2'd0, 2'd3, 4'd0, S_PCW};
        vecs[12] = '{BR,    3'b000, 7'h00, 1,0,0, 4'b0000, 0, 2'd0, 2'd3, 4'd2, S_PCW};
        vecs[13] = '{BR,    3'b001, 7'h00, 1,0,0, 4'b0000, 0, 2'd0, 2'd3, 4'd0, S_PCW};
        vecs[14] = '{BR,    3'b111, 7'h00, 0,0,0, 4'b0000, 0, 2'd0, 2'd3, 4'd2, S_PCW};
        vecs[15] = '{ST,    3'b010, 7'h00, 0,0,0, 4'b0000, 0, 2'd2, 2'd3, 4'd0, S_PCW|S_MEMW};
        vecs[16] = '{SYS,   3'b001, 7'h00, 0,0,0, 4'b1001, 0, 2'd0, 2'd1, 4'd0, S_PCW|S_REGW|S_CSR};
        vecs[17] = '{SYS,   3'b000, 7'h18, 0,0,0, 4'b1001, 0, 2'd0, 2'd1, 4'd5, S_PCW};
        vecs[18] = '{7'h00, 3'b000, 7'h00, 0,0,0, 4'b0000, 0, 2'd0, 2'd3, 4'd0, S_PCW|S_ILL};
        vecs[19] = '{7'h7F, 3'b000, 7'h00, 0,0,0, 4'b0000, 0, 2'd0, 2'd3, 4'd0, S_PCW|S_ILL};

        // reset: strobes low, cause zero
        RST_N = 1'b0;
        set_instr(OP, 3'b000, 7'h00);
        CU_BR_EQ = 0; CU_BR_LT = 0; CU_BR_LTU = 0;
        CU_IRQ = 4'b0000; CU_IRQ_MASK = 4'b0000; CU_MIE = 0; CU_ENC_DONE = 0;
        @(posedge CLK); @(posedge CLK); #1;
        check("reset_strobes", mk(4'b0000, 0, 2'd0, 2'd3, 4'd0, S_NONE));
        check_cause("reset_cause", 2'd0);
        RST_N = 1'b1;

        // decode table: FETCH then EXEC for each single-execute instruction
        for (int i = 0; i < 20; i++) begin
            set_instr(vecs[i].op, vecs[i].f3, vecs[i].f7);
            CU_BR_EQ = vecs[i].eq; CU_BR_LT = vecs[i].lt; CU_BR_LTU = vecs[i].ltu;
            cyc($sformatf("vec%0d_fetch", i),
                mk(vecs[i].alu, vecs[i].srca, vecs[i].srcb, vecs[i].rf, vecs[i].pcs, S_RD1));
            cyc($sformatf("vec%0d_exec", i),
                mk(vecs[i].alu, vecs[i].srca, vecs[i].srcb, vecs[i].rf, vecs[i].pcs, vecs[i].stb));
        end
        CU_BR_EQ = 0; CU_BR_LT = 0; CU_BR_LTU = 0;

        // LOAD: FETCH, EXEC, WB
        set_instr(LD, 3'b010, 7'h00);
        cyc("ld_fetch", mk(4'b0000, 0, 2'd1, 2'd2, 4'd0, S_RD1));
        cyc("ld_exec",  mk(4'b0000, 0, 2'd1, 2'd2, 4'd0, S_RD2));
        cyc("ld_wb",    mk(4'b0000, 0, 2'd1, 2'd2, 4'd0, S_PCW|S_REGW));

        // ENCRY, done ignored in FETCH/EXEC, then 5 idle waits and done
        set_instr(ENC, 3'b000, 7'h00);
        CU_ENC_DONE = 1;
        cyc("enc_fetch", mk(4'b0000, 0, 2'd0, 2'd3, 4'd0, S_RD1));
        cyc("enc_exec",  mk(4'b0000, 0, 2'd0, 2'd3, 4'd0, S_ENC));
        CU_ENC_DONE = 0;
        for (int k = 0; k < 5; k++)
            cyc($sformatf("enc_wait%0d", k), mk(4'b0000, 0, 2'd0, 2'd3, 4'd0, S_NONE));
        CU_ENC_DONE = 1;
        cyc("enc_done", mk(4'b0000, 0, 2'd0, 2'd3, 4'd0, S_PCW));
        CU_ENC_DONE = 0;

`ifdef CU_ENC_TIMEOUT_EN
        // timeout fires on the 8th wait cycle
        cyc("to_fetch", mk(4'b0000, 0, 2'd0, 2'd3, 4'd0, S_RD1));
        cyc("to_exec",  mk(4'b0000, 0, 2'd0, 2'd3, 4'd0, S_ENC));
        for (int k = 0; k < 7; k++)
            cyc($sformatf("to_wait%0d", k), mk(4'b0000, 0, 2'd0, 2'd3, 4'd0, S_NONE));
        cyc("to_err", mk(4'b0000, 0, 2'd0, 2'd3, 4'd0, S_PCW|S_ERR));
        // done on the final cycle wins over the timeout
        cyc("tod_fetch", mk(4'b0000, 0, 2'd0, 2'd3, 4'd0, S_RD1));
        cyc("tod_exec",  mk(4'b0000, 0, 2'd0, 2'd3, 4'd0, S_ENC));
        for (int k = 0; k < 7; k++)
            cyc($sformatf("tod_wait%0d", k), mk(4'b0000, 0, 2'd0, 2'd3, 4'd0, S_NONE));
        CU_ENC_DONE = 1;
        cyc("tod_done", mk(4'b0000, 0, 2'd0, 2'd3, 4'd0, S_PCW));
        CU_ENC_DONE = 0;
`else
        // without the watchdog ENC_WAIT holds indefinitely
        cyc("nto_fetch", mk(4'b0000, 0, 2'd0, 2'd3, 4'd0, S_RD1));
        cyc("nto_exec",  mk(4'b0000, 0, 2'd0, 2'd3, 4'd0, S_ENC));
        for (int k = 0; k < 20; k++)
            cyc($sformatf("nto_wait%0d", k), mk(4'b0000, 0, 2'd0, 2'd3, 4'd0, S_NONE));
        CU_ENC_DONE = 1;
        cyc("nto_done", mk(4'b0000, 0, 2'd0, 2'd3, 4'd0, S_PCW));
        CU_ENC_DONE = 0;
`endif

        // IRQ raised during FETCH of OP_IMM, taken after EXEC
        set_instr(OPI, 3'b000, 7'h00);
        CU_IRQ = 4'b1010; CU_IRQ_MASK = 4'b1110; CU_MIE = 1;
        cyc("irq_fetch", mk(4'b0000, 0, 2'd1, 2'd3, 4'd0, S_RD1));
        cyc("irq_exec",  mk(4'b0000, 0, 2'd1, 2'd3, 4'd0, S_PCW|S_REGW));
        cyc("irq_intr",  mk(4'b0000, 0, 2'd1, 2'd3, 4'd4, S_PCW|S_INT));
        check_cause("irq_cause1", 2'd1);
        // MIE=0 suppresses the trap
        CU_MIE = 0;
        cyc("nomie_fetch", mk(4'b0000, 0, 2'd1, 2'd3, 4'd0, S_RD1));
        cyc("nomie_exec",  mk(4'b0000, 0, 2'd1, 2'd3, 4'd0, S_PCW|S_REGW));
        // lowest-index active line wins
        set_instr(OP, 3'b000, 7'h00);
        CU_IRQ = 4'b1111; CU_IRQ_MASK = 4'b1100; CU_MIE = 1;
        cyc("pri_fetch", mk(4'b0000, 0, 2'd0, 2'd3, 4'd0, S_RD1));
        cyc("pri_exec",  mk(4'b0000, 0, 2'd0, 2'd3, 4'd0, S_PCW|S_REGW));
        cyc("pri_intr",  mk(4'b0000, 0, 2'd0, 2'd3, 4'd4, S_PCW|S_INT));
        check_cause("pri_cause2", 2'd2);
        CU_IRQ = 4'b0000;

        // IRQ during ENC_WAIT waits; done with IRQ pending completes then traps
        set_instr(ENC, 3'b000, 7'h00);
        cyc("ei_fetch", mk(4'b0000, 0, 2'd0, 2'd3, 4'd0, S_RD1));
        cyc("ei_exec",  mk(4'b0000, 0, 2'd0, 2'd3, 4'd0, S_ENC));
        CU_IRQ = 4'b1000; CU_IRQ_MASK = 4'b1000;
        cyc("ei_wait0", mk(4'b0000, 0, 2'd0, 2'd3, 4'd0, S_NONE));
        cyc("ei_wait1", mk(4'b0000, 0, 2'd0, 2'd3, 4'd0, S_NONE));
        CU_ENC_DONE = 1;
        cyc("ei_done",  mk(4'b0000, 0, 2'd0, 2'd3, 4'd0, S_PCW));
        CU_ENC_DONE = 0;
        cyc("ei_intr",  mk(4'b0000, 0, 2'd0, 2'd3, 4'd4, S_PCW|S_INT));
        check_cause("ei_cause3", 2'd3);
        CU_IRQ = 4'b0000; CU_MIE = 0;

        // reset mid-ENC_WAIT, then an illegal opcode
        cyc("rst_fetch", mk(4'b0000, 0, 2'd0, 2'd3, 4'd0, S_RD1));
        cyc("rst_exec",  mk(4'b0000, 0, 2'd0, 2'd3, 4'd0, S_ENC));
        cyc("rst_wait0", mk(4'b0000, 0, 2'd0, 2'd3, 4'd0, S_NONE));
        #2;
        RST_N = 1'b0;
        #1;
        check("rst_async_strobes", mk(4'b0000, 0, 2'd0, 2'd3, 4'd0, S_NONE));
        check_cause("rst_async_cause", 2'd0);
        @(posedge CLK); #1;
        set_instr(7'b0000000, 3'b000, 7'h00);
        RST_N = 1'b1;
        cyc("ill_fetch", mk(4'b0000, 0, 2'd0, 2'd3, 4'd0, S_RD1));
        cyc("ill_exec",  mk(4'b0000, 0, 2'd0, 2'd3, 4'd0, S_PCW|S_ILL));
        cyc("ill_back",  mk(4'b0000, 0, 2'd0, 2'd3, 4'd0, S_RD1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/otter_cu_fsm_decoder.md
Name: otter_cu_fsm_decoder

Overview:
Second-generation OTTER control unit: a multicycle FSM merged with the instruction decoder.
- Sequences fetch/execute/writeback.
- Arbitrates a parametrised vector of maskable interrupt sources with priority encoding.
- Issues ENCRY instructions to the crypto coprocessor over a start/done handshake, stalling the PC until done.
- Sits between instruction memory, register file, CSR file, ALU muxes and the crypto module.

Parameters:
IRQ_W, 4, number of interrupt request lines (1..16)
PCSRC_W, 4, width of CU_PCSOURCE
ENC_TIMEOUT, 64, max ENC_WAIT cycles before abort (only used when the timeout feature is compiled in)

Ports:
CLK  in  1  clock
RST_N  in  1  asynchronous active-low reset
CU_OPCODE  in  7  instruction[6:0]
CU_FUNC3  in  3  instruction[14:12]
CU_FUNC7  in  7  instruction[31:25]
CU_BR_EQ, CU_BR_LT, CU_BR_LTU  in  1 each  branch comparator flags
CU_IRQ  in  IRQ_W  level-sensitive interrupt requests
CU_IRQ_MASK  in  IRQ_W  per-line enable
CU_MIE  in  1  global interrupt enable (from CSR)
CU_ENC_DONE  in  1  crypto unit completion pulse
CU_PC_WRITE, CU_REG_WRITE, CU_MEM_WE, CU_MEM_RDEN1, CU_MEM_RDEN2, CU_CSR_WE  out  1 each  datapath strobes
CU_ENC_START  out  1  one-cycle crypto start
CU_INT_TAKEN  out  1  interrupt entry strobe
CU_INT_CAUSE  out  max(1,$clog2(IRQ_W))  latched cause index
CU_ILLEGAL  out  1  unknown-opcode pulse
CU_ENC_ERR  out  1  timeout pulse
CU_ALU_SRCA  out  1
CU_ALU_SRCB  out  2
CU_ALU_FUN  out  4
CU_RF_WR_SEL  out  2
CU_PCSOURCE  out  PCSRC_W

Behaviour:
Reset and decode:
- Reset: async on RST_N low. State goes to FETCH; CU_INT_CAUSE=0; timeout counter=0. All strobes are forced 0 while RST_N is low.
- Decode is combinational from opcode/func fields in every state.
- ALU_FUN:
  - OP: {f7[5],f3}
  - OP_IMM: {f7[5],f3} if f3==101, else {0,f3}
  - LUI, SYSTEM: 1001
  - all others: 0000
- ALU_SRCA=1 for LUI/AUIPC, else 0.
- ALU_SRCB: STORE 2; LOAD, JALR, OP_IMM 1; AUIPC 3; else 0.
- RF_WR_SEL: JAL/JALR 0; SYSTEM 1; LOAD 2; else 3.
- PCSOURCE:
  - JAL 3; JALR 1; BRANCH taken 2, untaken 0; SYSTEM f3==000 (mret) 5; else 0.
  - Forced to 4 in INTR state.
  - Upper bits zero-extended to PCSRC_W.
- Branch condition by f3: 000 EQ, 001 !EQ, 100 LT, 101 !LT, 110 LTU, 111 !LTU; other f3 = not taken.

State machine:
- FETCH: MEM_RDEN1=1 -> EXEC.
- EXEC:
  - PC_WRITE=1 except LOAD/ENCRY.
  - REG_WRITE for LUI, AUIPC, JAL, JALR, OP, OP_IMM, and SYSTEM with f3!=0.
  - CSR_WE for SYSTEM with f3!=0; MEM_WE for STORE; MEM_RDEN2 for LOAD.
  - ENC_START=1 for ENCRY (0011100).
  - Unrecognised opcode: CU_ILLEGAL=1, PC_WRITE=1, no other writes.
  - Next: LOAD -> WB; ENCRY -> ENC_WAIT; else INTR if pending, else FETCH.
- WB: REG_WRITE=1, PC_WRITE=1 -> INTR if pending, else FETCH.
- ENC_WAIT: holds with all strobes 0 until CU_ENC_DONE. On done: PC_WRITE=1 -> INTR if pending, else FETCH.
- INTR: INT_TAKEN=1, PC_WRITE=1, PCSOURCE=4; CU_INT_CAUSE latches the lowest-index active line -> FETCH.

Interrupt rules:
- pending = CU_MIE & |(CU_IRQ & CU_IRQ_MASK), sampled only at the instruction boundary (end of EXEC/WB/ENC_WAIT).
- Never taken mid-ENCRY.
- An interrupt arriving during FETCH waits for the boundary.
- CU_ENC_DONE outside ENC_WAIT is ignored.
- CU_ENC_DONE in the same cycle as a pending IRQ completes the instruction, then goes to INTR.
- Reset mid-ENC_WAIT: returns to FETCH, no ENC_ERR.

Optional Feature:
- CU_ENC_TIMEOUT_EN defined:
  - Counter clears on ENC_WAIT entry and counts each ENC_WAIT cycle.
  - When it reaches ENC_TIMEOUT-1 without done: CU_ENC_ERR=1 for one cycle, PC_WRITE=1, exit as on done.
  - Done on the final cycle takes priority (no error).
- Undefined: no counter; ENC_WAIT waits indefinitely; CU_ENC_ERR tied 0.

Test Plan:
- OP add (f3=000, f7=0) after reset -> FETCH (RDEN1=1), EXEC: ALU_FUN=0000, SRCB=0, RF_WR_SEL=3, REG_WRITE=1, PC_WRITE=1; back to FETCH.
- LOAD -> EXEC: RDEN2=1, PC_WRITE=0; WB: REG_WRITE=1, PC_WRITE=1, RF_WR_SEL=2; 3 cycles total.
- BLT with CU_BR_LT=1 -> PCSOURCE=2; with CU_BR_LT=0 -> 0; f3=010 -> 0.
- ENCRY, CU_ENC_DONE after 5 cycles -> ENC_START pulse in EXEC, 5 idle cycles, PC_WRITE on the done cycle.
  - With CU_ENC_TIMEOUT_EN and ENC_TIMEOUT=8 and no done -> ENC_ERR pulse on the 8th wait cycle.
- IRQ=4'b1010, MASK=4'b1110, MIE=1 during OP_IMM -> INTR follows EXEC, INT_CAUSE=1, PCSOURCE=4.
  - With MIE=0 -> no INTR.
- RST_N low during ENC_WAIT -> immediate FETCH, all strobes 0, INT_CAUSE=0; opcode 0000000 -> CU_ILLEGAL pulse, PC_WRITE=1.
